// File: rtl/vdp_cpu_port_pkg.sv
// Shared VDP definitions: CPU-port FSM state encodings and control-port command codes.
`ifndef VDP_CPU_PORT_PKG_SV
`define VDP_CPU_PORT_PKG_SV

package vdp_cpu_port_pkg;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_WR_REQ     = 2'b01;
  localparam logic [1:0] ST_RD_REQ     = 2'b10;
  localparam logic [1:0] ST_RD_CAPTURE = 2'b11;

  typedef enum logic [1:0] {
    CMD_RD_SETUP = 2'b00,
    CMD_WR_SETUP = 2'b01,
    CMD_REG_WR   = 2'b10,
    CMD_PAL_WR   = 2'b11
  } vdp_cmd_t;

  localparam logic [2:0] PAGE_REG_INDEX = 3'd7;

  function automatic logic [7:0] vdp_status(input logic busy, input logic overrun,
                                            input logic phase);
    return {busy, overrun, phase, 5'b00000};
  endfunction

endpackage

`endif

// File: rtl/vdp_cpu_port.sv
// VDP CPU interface: control/data port decode, VRAM access sequencing with
// read-ahead buffer, register and palette write pulses.
module vdp_cpu_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int RamBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuSelect,
  input  logic               cpuWrite,
  input  logic               cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               vramReq,
  input  logic               vramGrant,
  output logic [RamBits-1:0] vramAddress,
  output logic               vramWriteEnabled,
  output logic [7:0]         vramDataWrite,
  input  logic [7:0]         vramDataRead,
  output logic               regWrite,
  output logic [2:0]         regIndex,
  output logic [7:0]         regData,
  output logic               palWrite,
  output logic [3:0]         palIndex,
  output logic [7:0]         palData,
  output logic               busy
);

  localparam int PageBits = RamBits - 14;
  localparam logic [RamBits-1:0] AddrOne = RamBits'(1);

  logic [1:0]          r_state;
  logic [RamBits-1:0]  r_address;
  logic [PageBits-1:0] r_page;
  logic [7:0]          r_low_byte;
  logic                r_phase;
  logic                r_overrun;
  logic [7:0]          r_read_buffer;
  logic [7:0]          r_wr_data;

  logic               w_busy;
  logic               w_take;
  logic               w_data_acc;
  logic               w_ctrl_wr;
  logic               w_ctrl_rd;
  logic               w_cmd_exec;
  vdp_cmd_t           w_cmd;
  logic               w_issue_wr;
  logic               w_issue_rd;
  logic               w_load_addr;
  logic               w_drop;
  logic [RamBits-1:0] w_setup_addr;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_take     = vramReq && vramGrant;
  assign w_data_acc = cpuSelect && !cpuPort;
  assign w_ctrl_wr  = cpuSelect && cpuPort && cpuWrite;
  assign w_ctrl_rd  = cpuSelect && cpuPort && !cpuWrite;
  assign w_cmd_exec = w_ctrl_wr && r_phase;
  assign w_cmd      = vdp_cmd_t'(cpuDataIn[7:6]);

  assign w_setup_addr = {r_page, cpuDataIn[5:0], r_low_byte};

  assign w_issue_wr  = w_data_acc && cpuWrite && !w_busy;
  assign w_issue_rd  = (w_data_acc && !cpuWrite && !w_busy)
                    || (w_cmd_exec && (w_cmd == CMD_RD_SETUP) && !w_busy);
  assign w_load_addr = w_cmd_exec && (((w_cmd == CMD_RD_SETUP) && !w_busy)
                                   || (w_cmd == CMD_WR_SETUP));
  assign w_drop      = (w_data_acc && w_busy)
                    || (w_cmd_exec && (w_cmd == CMD_RD_SETUP) && w_busy);

  assign vramReq          = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
  assign vramWriteEnabled = (r_state == ST_WR_REQ);
  assign vramAddress      = r_address;
  assign vramDataWrite    = r_wr_data;
  assign busy             = w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_address     <= '0;
      r_page        <= '0;
      r_low_byte    <= '0;
      r_phase       <= 1'b0;
      r_overrun     <= 1'b0;
      r_read_buffer <= '0;
      r_wr_data     <= '0;
      cpuDataOut    <= '0;
      regWrite      <= 1'b0;
      regIndex      <= '0;
      regData       <= '0;
      palWrite      <= 1'b0;
      palIndex      <= '0;
      palData       <= '0;
    end else begin
      regWrite <= 1'b0;
      palWrite <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_issue_wr)      r_state <= ST_WR_REQ;
          else if (w_issue_rd) r_state <= ST_RD_REQ;
        end
        ST_WR_REQ: if (vramGrant) r_state <= ST_IDLE;
        ST_RD_REQ: if (vramGrant) r_state <= ST_RD_CAPTURE;
        ST_RD_CAPTURE: begin
          r_read_buffer <= vramDataRead;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A CPU address load overrides the post-access increment in the same cycle.
      if (w_load_addr)  r_address <= w_setup_addr;
      else if (w_take)  r_address <= r_address + AddrOne;

      if (w_issue_wr) r_wr_data <= cpuDataIn;

      if (w_data_acc || w_ctrl_rd) r_phase <= 1'b0;
      else if (w_ctrl_wr)          r_phase <= ~r_phase;

      if (w_ctrl_wr && !r_phase) r_low_byte <= cpuDataIn;

      if (w_ctrl_rd)   r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;

      if (w_data_acc && !cpuWrite) cpuDataOut <= r_read_buffer;
      else if (w_ctrl_rd)          cpuDataOut <= vdp_status(w_busy, r_overrun, r_phase);

      if (w_cmd_exec && (w_cmd == CMD_REG_WR)) begin
        regWrite <= 1'b1;
        regIndex <= cpuDataIn[2:0];
        regData  <= r_low_byte;
        if (cpuDataIn[2:0] == PAGE_REG_INDEX) r_page <= r_low_byte[PageBits-1:0];
      end

      if (w_cmd_exec && (w_cmd == CMD_PAL_WR)) begin
        palWrite <= 1'b1;
        palIndex <= cpuDataIn[3:0];
        palData  <= r_low_byte;
      end
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a simple VRAM model behind an externally held grant.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuSelect, cpuWrite, cpuPort;
  logic [7:0]  cpuDataIn, cpuDataOut;
  logic        vramReq, vramGrant, vramWriteEnabled;
  logic [15:0] vramAddress;
  logic [7:0]  vramDataWrite;
  logic [7:0]  vramDataRead = 8'h00;
  logic        regWrite, palWrite, busy;
  logic [2:0]  regIndex;
  logic [3:0]  palIndex;
  logic [7:0]  regData, palData;

  logic [7:0]  mem [0:65535];
  int          wr_count = 0;
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  int n_tests = 0;
  int n_fail  = 0;

  vdp_cpu_port #(.RamBits(16)) dut (
    .clk(clk), .reset(reset),
    .cpuSelect(cpuSelect), .cpuWrite(cpuWrite), .cpuPort(cpuPort),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut),
    .vramReq(vramReq), .vramGrant(vramGrant), .vramAddress(vramAddress),
    .vramWriteEnabled(vramWriteEnabled), .vramDataWrite(vramDataWrite),
    .vramDataRead(vramDataRead),
    .regWrite(regWrite), .regIndex(regIndex), .regData(regData),
    .palWrite(palWrite), .palIndex(palIndex), .palData(palData),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // VRAM: access on req&grant, read data one cycle later
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (vramReq && vramGrant) begin
      if (vramWriteEnabled) begin
        mem[vramAddress] <= vramDataWrite;
        wr_count <= wr_count + 1;
      end else begin
        vramDataRead <= mem[vramAddress];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu(input logic port, input logic wr, input logic [7:0] d);
    cpuSelect = 1'b1; cpuPort = port; cpuWrite = wr; cpuDataIn = d;
    @(negedge clk);
    cpuSelect = 1'b0; cpuWrite = 1'b0; cpuDataIn = 8'h00;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cpuSelect = 1'b0; cpuWrite = 1'b0; cpuPort = 1'b0; cpuDataIn = 8'h00;
    vramGrant = 1'b1; pre_we = 1'b0; pre_addr = 16'h0; pre_data = 8'h0;
    tick(3);
    check("rst_req",   {31'd0, vramReq},  32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_addr",  {16'd0, vramAddress}, 32'h0);
    check("rst_dout",  {24'd0, cpuDataOut},  32'h0);
    check("rst_pulse", {30'd0, regWrite, palWrite}, 32'd0);
    reset = 1'b0;
    tick(1);

    preload(16'hFFFF, 8'h11);
    preload(16'h0000, 8'h22);
    preload(16'h1000, 8'h77);

    // write setup 0x1234, two data writes with grant high
    cpu(1'b1, 1'b1, 8'h34);
    cpu(1'b1, 1'b1, 8'h52);
    check("wsetup_addr", {16'd0, vramAddress}, 32'h1234);
    check("wsetup_busy", {31'd0, busy}, 32'd0);
    cpu(1'b0, 1'b1, 8'hAA);
    check("wr1_req",  {30'd0, vramReq, vramWriteEnabled}, 32'd3);
    check("wr1_data", {24'd0, vramDataWrite}, 32'hAA);
    tick(1);
    check("wr1_done", {31'd0, busy}, 32'd0);
    check("wr1_inc",  {16'd0, vramAddress}, 32'h1235);
    cpu(1'b0, 1'b1, 8'hBB);
    tick(1);
    check("mem_1234", {24'd0, mem[16'h1234]}, 32'hAA);
    check("mem_1235", {24'd0, mem[16'h1235]}, 32'hBB);
    check("wr_addr_end", {16'd0, vramAddress}, 32'h1236);
    check("wr_count2", wr_count, 32'd2);

    // register and palette pulses
    cpu(1'b1, 1'b1, 8'h05);
    cpu(1'b1, 1'b1, 8'h80);
    check("reg_pulse", {31'd0, regWrite}, 32'd1);
    check("reg_idx",   {29'd0, regIndex}, 32'd0);
    check("reg_data",  {24'd0, regData},  32'h05);
    tick(1);
    check("reg_pulse_end", {31'd0, regWrite}, 32'd0);
    cpu(1'b1, 1'b1, 8'h1D);
    cpu(1'b1, 1'b1, 8'hC1);
    check("pal_pulse", {31'd0, palWrite}, 32'd1);
    check("pal_idx",   {28'd0, palIndex}, 32'd1);
    check("pal_data",  {24'd0, palData},  32'h1D);
    check("pal_no_reg", {31'd0, regWrite}, 32'd0);
    tick(1);
    check("pal_pulse_end", {31'd0, palWrite}, 32'd0);

    // page 3, read setup at 0xFFFF, reads across the wrap
    cpu(1'b1, 1'b1, 8'h03);
    cpu(1'b1, 1'b1, 8'h87);
    cpu(1'b1, 1'b1, 8'hFF);
    cpu(1'b1, 1'b1, 8'h3F);
    check("rsetup_req",  {30'd0, vramReq, vramWriteEnabled}, 32'd2);
    check("rsetup_addr", {16'd0, vramAddress}, 32'hFFFF);
    tick(1);
    check("rcap_busy", {30'd0, busy, vramReq}, 32'd2);
    check("rwrap_addr", {16'd0, vramAddress}, 32'h0000);
    tick(1);
    check("rlat2_idle", {31'd0, busy}, 32'd0);
    cpu(1'b0, 1'b0, 8'h00);
    check("rd1_data", {24'd0, cpuDataOut}, 32'h11);
    tick(2);
    check("rd1_idle", {31'd0, busy}, 32'd0);
    check("rd1_addr", {16'd0, vramAddress}, 32'h0001);
    cpu(1'b0, 1'b0, 8'h00);
    check("rd2_data", {24'd0, cpuDataOut}, 32'h22);
    tick(2);
    cpu(1'b1, 1'b1, 8'h00);
    cpu(1'b1, 1'b1, 8'h87);

    // stalled write, second write dropped
    cpu(1'b1, 1'b1, 8'h00);
    cpu(1'b1, 1'b1, 8'h41);
    check("stall_setup", {16'd0, vramAddress}, 32'h0100);
    vramGrant = 1'b0;
    cpu(1'b0, 1'b1, 8'h5A);
    cpu(1'b0, 1'b1, 8'h6B);
    tick(1);
    check("stall_wdata", {24'd0, vramDataWrite}, 32'h5A);
    check("stall_req",   {31'd0, vramReq}, 32'd1);
    cpu(1'b1, 1'b0, 8'h00);
    check("stall_status", {24'd0, cpuDataOut}, 32'hC0);
    tick(1);
    vramGrant = 1'b1;
    wait_idle("stall_idle", 20);
    check("stall_addr",  {16'd0, vramAddress}, 32'h0101);
    check("stall_mem",   {24'd0, mem[16'h0100]}, 32'h5A);
    check("wr_count3",   wr_count, 32'd3);
    cpu(1'b1, 1'b0, 8'h00);
    check("status_clr", {24'd0, cpuDataOut}, 32'h00);

    // half control sequence, status read resets phase
    cpu(1'b1, 1'b1, 8'h34);
    cpu(1'b1, 1'b0, 8'h00);
    check("phase_status", {24'd0, cpuDataOut}, 32'h20);
    cpu(1'b1, 1'b1, 8'h78);
    cpu(1'b1, 1'b1, 8'h40);
    check("phase_reset_addr", {16'd0, vramAddress}, 32'h0078);

    // reset during RD_REQ
    vramGrant = 1'b0;
    cpu(1'b1, 1'b1, 8'h00);
    cpu(1'b1, 1'b1, 8'h10);
    check("rreq_pending", {30'd0, vramReq, vramWriteEnabled}, 32'd2);
    check("rreq_addr", {16'd0, vramAddress}, 32'h1000);
    reset = 1'b1;
    tick(1);
    check("mid_rst_req",  {30'd0, vramReq, busy}, 32'd0);
    check("mid_rst_addr", {16'd0, vramAddress}, 32'h0000);
    reset = 1'b0;
    vramGrant = 1'b1;
    tick(1);
    cpu(1'b0, 1'b0, 8'h00);
    check("mid_rst_buf", {24'd0, cpuDataOut}, 32'h00);
    tick(2);
    cpu(1'b1, 1'b0, 8'h00);
    check("mid_rst_status", {24'd0, cpuDataOut}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 Parameter: RamBits, 16, VRAM address width (VRAM size 2^RamBits bytes).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpuSelect  in  1  one-cycle access strobe.
REQ-005 cpuWrite  in  1  1=write, 0=read, valid with cpuSelect.
REQ-006 cpuPort  in  1  0=data port, 1=control port.
REQ-007 cpuDataIn  in  8  CPU write data.
REQ-008 cpuDataOut  out  8  CPU read data, registered, valid the cycle after the read strobe.
REQ-009 vramReq  out  1  VRAM access request, held until granted.
REQ-010 vramGrant  in  1  arbiter grant; access occurs in the cycle where vramReq and vramGrant are both high.
REQ-011 vramAddress  out  RamBits  VRAM address, stable while vramReq is high.
REQ-012 vramWriteEnabled  out  1  1=write access, 0=read access, valid with vramReq.
REQ-013 vramDataWrite  out  8  VRAM write data.
REQ-014 vramDataRead  in  8  VRAM read data, valid one cycle after the granted read.
REQ-015 regWrite / regIndex[2:0] / regData[7:0]  out  one-cycle VDP register write pulse, index, data.
REQ-016 palWrite / palIndex[3:0] / palData[7:0]  out  one-cycle palette write pulse, index, rrrgggbb data.
REQ-017 busy  out  1  high while a VRAM access is pending.

Function
REQ-018 Control-port writes alternate phase 0/1; phase 0 latches the byte as lowByte; phase 1 executes a command chosen by bits 7:6.
REQ-019 Command 00 (read setup): address[13:0]={b[5:0],lowByte}, address[RamBits-1:14]=page; issue a prefetch read.
REQ-020 Command 01 (write setup): load address as in REQ-019; no VRAM access.
REQ-021 Command 10: pulse regWrite for one cycle with regIndex=b[2:0] and regData=lowByte; if index is 7, page <= lowByte[RamBits-15:0].
REQ-022 Command 11: pulse palWrite for one cycle with palIndex=b[3:0] and palData=lowByte.
REQ-023 Data-port write while not busy: issue a VRAM write of cpuDataIn at address; address increments once the grant is taken.
REQ-024 Data-port read: cpuDataOut = readBuffer, then issue a prefetch read at address; address increments once the grant is taken.
REQ-025 A prefetch result is stored in readBuffer in the cycle after the grant.
REQ-026 Control-port read: cpuDataOut = {busy, overrun, phase, 5'b0}; clears phase to 0 and clears overrun.
REQ-027 Any data-port access resets phase to 0.
REQ-028 A data-port access while busy is dropped and sets the sticky overrun flag; a data read while busy returns the stale readBuffer.
REQ-029 A control-port access while busy is accepted; a read setup while busy is dropped and sets overrun.
REQ-030 FSM states: IDLE; WR_REQ (vramReq=1, we=1); RD_REQ (vramReq=1, we=0); RD_CAPTURE (latch vramDataRead).
REQ-031 FSM transitions: IDLE->WR_REQ/RD_REQ on issue; WR_REQ->IDLE on grant; RD_REQ->RD_CAPTURE on grant; RD_CAPTURE->IDLE.
REQ-032 busy = state != IDLE.
REQ-033 If grant is already high in the first request cycle, the access completes in that cycle, giving minimum write occupancy of 1 cycle and minimum read-to-buffer latency of 2 cycles.
REQ-034 Address increment wraps modulo 2^RamBits (all-ones -> 0), including across the page bits.

Reset
REQ-035 Reset SHALL clear outputs and state as follows: state=IDLE; address=0; page=0; lowByte=0; phase=0; overrun=0; readBuffer=0; cpuDataOut=0; all request and pulse outputs 0.
REQ-036 Reset in mid-access SHALL abandon the access with no increment and no buffer update.

Structure
REQ-037 FSM state encodings and command codes (00/01/10/11) SHALL live in a shared vdp package header, guarded like the other VDP headers.
REQ-038 The design SHALL be a single module with no sub-modules; the arbiter is external.

Verification
REQ-039 Control writes 0x34, 0x52 (write setup), then data writes 0xAA, 0xBB with grant held high -> VRAM writes 0xAA at 0x1234 and 0xBB at 0x1235; final address 0x1236.
REQ-040 Control writes 0x05, 0x80 -> a one-cycle regWrite with regIndex=0 and regData=0x05; control writes 0x1D, 0xC1 -> a one-cycle palWrite with palIndex=1 and palData=0x1D.
REQ-041 Page 3 via reg 7, then read setup 0xFF/0x3F with RAM[0xFFFF]=0x11 and RAM[0]=0x22 -> the first data read returns 0x11 and the second data read returns 0x22, the address having wrapped to 0.
REQ-042 Grant held low for 5 cycles during a write with a second data write issued meanwhile -> the second write is dropped and the status read returns 0xC0 (busy and overrun set); a following status read returns overrun=0.
REQ-043 Control write 0x34 only, then status read -> status returns 0x20; the next control write is treated as phase 0.
REQ-044 Reset asserted during RD_REQ -> the next cycle shows vramReq=0, busy=0, address=0, and readBuffer unchanged at 0.
